// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch sequencer: latches one branch/jump request, drives the
// external comparator, registers the outcome and holds fetch in flush after a redirect.
module branch_resolve_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_kind,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_imm,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic [2:0]      cmp_funct3,
  output logic [XLEN-1:0] cmp_op1,
  output logic [XLEN-1:0] cmp_op2,
  input  logic            cmp_br_sig,
  input  logic            kill,
  output logic            resp_valid,
  output logic            resp_taken,
  output logic [XLEN-1:0] resp_target,
  output logic [XLEN-1:0] resp_link,
  output logic            resp_fault,
  output logic            flush,
  output logic [15:0]     taken_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESP, S_FLUSH} state_t;

  localparam logic [1:0] K_BRANCH = 2'b00;
  localparam logic [1:0] K_JALR   = 2'b10;
  localparam logic [1:0] K_RSVD   = 2'b11;
  localparam int         CW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t            r_state, w_next;
  logic [1:0]        r_kind;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_pc, r_imm, r_rs1, r_rs2;
  logic              r_resp_valid, r_resp_taken, r_resp_fault;
  logic [XLEN-1:0]   r_resp_target, r_resp_link;
  logic [15:0]       r_taken_cnt;
  logic [CW-1:0]     r_flush_cnt;

  logic              w_accept;
  logic [XLEN-1:0]   w_target;
  logic              w_illegal, w_taken_raw, w_fault, w_taken;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (kill) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (req_valid) w_next = S_EVAL;
        S_EVAL:  w_next = S_RESP;
        S_RESP:  w_next = r_resp_taken ? S_FLUSH : S_IDLE;
        S_FLUSH: if (r_flush_cnt == '0) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE) && !kill;
    flush      = (r_state == S_FLUSH);
    cmp_funct3 = '0;
    cmp_op1    = '0;
    cmp_op2    = '0;
    if (r_state == S_EVAL) begin
      cmp_funct3 = r_funct3;
      cmp_op1    = r_rs1;
      cmp_op2    = r_rs2;
    end
  end

  assign w_accept = req_valid && req_ready;

  // Request fields need no reset: they only reach outputs from EVAL onward.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_kind   <= req_kind;
      r_funct3 <= req_funct3;
      r_pc     <= req_pc;
      r_imm    <= req_imm;
      r_rs1    <= req_rs1;
      r_rs2    <= req_rs2;
    end
  end

  // funct3 010/011 have no branch meaning; a fault overrides any redirect.
  assign w_target    = (r_kind == K_JALR) ? ((r_rs1 + r_imm) & ~XLEN'(1)) : (r_pc + r_imm);
  assign w_illegal   = (r_kind == K_RSVD) || ((r_kind == K_BRANCH) && (r_funct3[2:1] == 2'b01));
  assign w_taken_raw = (r_kind == K_BRANCH) ? cmp_br_sig : 1'b1;
  assign w_fault     = w_illegal || (w_taken_raw && w_target[1]);
  assign w_taken     = w_taken_raw && !w_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid  <= 1'b0;
      r_resp_taken  <= 1'b0;
      r_resp_fault  <= 1'b0;
      r_resp_target <= '0;
      r_resp_link   <= '0;
      r_taken_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_resp_valid <= (r_state == S_EVAL) && !kill;
      if ((r_state == S_EVAL) && !kill) begin
        r_resp_taken  <= w_taken;
        r_resp_fault  <= w_fault;
        r_resp_target <= w_target;
        r_resp_link   <= r_pc + XLEN'(4);
      end
      if ((r_state == S_RESP) && r_resp_taken && !kill)
        r_taken_cnt <= sat_inc(r_taken_cnt);
      if (kill)
        r_flush_cnt <= '0;
      else if (r_state == S_RESP)
        r_flush_cnt <= CW'(FLUSH_CYCLES - 1);
      else if ((r_state == S_FLUSH) && (r_flush_cnt != '0))
        r_flush_cnt <= r_flush_cnt - 1'b1;
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_taken  = r_resp_taken;
  assign resp_fault  = r_resp_fault;
  assign resp_target = r_resp_target;
  assign resp_link   = r_resp_link;
  assign taken_cnt   = r_taken_cnt;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl with a behavioural comparator and outcome model.
module tb_branch_resolve_ctrl;
  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_ready, kill;
  logic [1:0]      req_kind;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_pc, req_imm, req_rs1, req_rs2;
  logic [2:0]      cmp_funct3;
  logic [XLEN-1:0] cmp_op1, cmp_op2;
  logic            cmp_br_sig;
  logic            resp_valid, resp_taken, resp_fault, flush;
  logic [XLEN-1:0] resp_target, resp_link;
  logic [15:0]     taken_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_cnt = 16'd0;

  branch_resolve_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_funct3(req_funct3), .req_pc(req_pc), .req_imm(req_imm),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .cmp_funct3(cmp_funct3), .cmp_op1(cmp_op1),
    .cmp_op2(cmp_op2), .cmp_br_sig(cmp_br_sig), .kill(kill), .resp_valid(resp_valid),
    .resp_taken(resp_taken), .resp_target(resp_target), .resp_link(resp_link),
    .resp_fault(resp_fault), .flush(flush), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  // External comparator; the undefined conditions answer 1 so ignoring them is observable.
  always_comb begin
    case (cmp_funct3)
      3'b000:  cmp_br_sig = (cmp_op1 == cmp_op2);
      3'b001:  cmp_br_sig = (cmp_op1 != cmp_op2);
      3'b100:  cmp_br_sig = ($signed(cmp_op1) <  $signed(cmp_op2));
      3'b101:  cmp_br_sig = ($signed(cmp_op1) >= $signed(cmp_op2));
      3'b110:  cmp_br_sig = (cmp_op1 <  cmp_op2);
      3'b111:  cmp_br_sig = (cmp_op1 >= cmp_op2);
      default: cmp_br_sig = 1'b1;
    endcase
  end

  function automatic void model(input logic [1:0] k, input logic [2:0] f,
                                input logic [31:0] pc, imm, rs1, rs2,
                                output logic tk, output logic flt,
                                output logic [31:0] tgt, output logic [31:0] lnk);
    logic cond, want, illegal;
    lnk = pc + 32'd4;
    tgt = (k == 2'b10) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    case (f)
      3'd0:    cond = (rs1 == rs2);
      3'd1:    cond = (rs1 != rs2);
      3'd4:    cond = ($signed(rs1) <  $signed(rs2));
      3'd5:    cond = ($signed(rs1) >= $signed(rs2));
      3'd6:    cond = (rs1 <  rs2);
      3'd7:    cond = (rs1 >= rs2);
      default: cond = 1'b0;
    endcase
    illegal = (k == 2'b11) || (k == 2'b00 && (f == 3'd2 || f == 3'd3));
    want    = (k == 2'b00) ? cond : 1'b1;
    if (illegal)              begin flt = 1'b1; tk = 1'b0; end
    else if (want && tgt[1])  begin flt = 1'b1; tk = 1'b0; end
    else                      begin flt = 1'b0; tk = want; end
  endfunction

  // Waits for ready, performs the handshake and returns one cycle later (EVAL).
  task automatic start_req(input logic [1:0] k, input logic [2:0] f,
                           input logic [31:0] pc, imm, rs1, rs2, input bit hold);
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
    end
    req_kind = k; req_funct3 = f; req_pc = pc; req_imm = imm; req_rs1 = rs1; req_rs2 = rs2;
    req_valid = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      req_funct3 = 3'($urandom); req_rs1 = $urandom; req_rs2 = $urandom; req_pc = $urandom;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic run_req(input logic [1:0] k, input logic [2:0] f,
                         input logic [31:0] pc, imm, rs1, rs2, input bit hold);
    logic tk, flt;
    logic [31:0] tgt, lnk;
    model(k, f, pc, imm, rs1, rs2, tk, flt, tgt, lnk);
    start_req(k, f, pc, imm, rs1, rs2, hold);
    checks++;
    if ({cmp_funct3, cmp_op1, cmp_op2} !== {f, rs1, rs2}) begin
      errors++; $display("FAIL eval_cmp: f3=%b op1=%h op2=%h required %b %h %h",
                         cmp_funct3, cmp_op1, cmp_op2, f, rs1, rs2);
    end
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL eval_ctl: valid=%b ready=%b required 0 0", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++; $display("FAIL resp_valid: got %b required 1", resp_valid);
    end
    checks++;
    if ({resp_taken, resp_fault} !== {tk, flt}) begin
      errors++; $display("FAIL outcome k=%b f=%b: taken/fault=%b%b required %b%b",
                         k, f, resp_taken, resp_fault, tk, flt);
    end
    checks++;
    if (resp_link !== lnk) begin
      errors++; $display("FAIL link: got %h required %h", resp_link, lnk);
    end
    if (k != 2'b11) begin
      checks++;
      if (resp_target !== tgt) begin
        errors++; $display("FAIL target: got %h required %h", resp_target, tgt);
      end
    end
    checks++;
    if (flush !== 1'b0 || {cmp_funct3, cmp_op1, cmp_op2} !== '0) begin
      errors++; $display("FAIL resp_ctl: flush=%b cmp_op1=%h required 0 0", flush, cmp_op1);
    end
    if (tk) begin
      exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
      for (int i = 0; i < FC; i++) begin
        @(posedge clk); #1;
        checks++;
        if (flush !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
          errors++; $display("FAIL flush_win%0d: flush=%b ready=%b valid=%b required 1 0 0",
                             i, flush, req_ready, resp_valid);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (flush !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_return: flush=%b ready=%b required 0 1", flush, req_ready);
    end
    checks++;
    if (taken_cnt !== exp_cnt) begin
      errors++; $display("FAIL taken_cnt: got %h required %h", taken_cnt, exp_cnt);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_taken !== 1'b0 || resp_fault !== 1'b0 ||
        resp_target !== '0 || resp_link !== '0 || flush !== 1'b0 || taken_cnt !== 16'd0 ||
        cmp_funct3 !== '0 || cmp_op1 !== '0 || cmp_op2 !== '0) begin
      errors++;
      $display("FAIL %s: ready=%b valid=%b taken=%b fault=%b tgt=%h link=%h flush=%b cnt=%h op1=%h required reset values",
               tag, req_ready, resp_valid, resp_taken, resp_fault, resp_target, resp_link,
               flush, taken_cnt, cmp_op1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; kill = 1'b0;
    req_kind = '0; req_funct3 = '0; req_pc = '0; req_imm = '0; req_rs1 = '0; req_rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_cnt = 16'd0;
  endtask

  task automatic test_directed();
    run_req(2'b00, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);          // beq taken
    run_req(2'b00, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0);  // blt taken
    run_req(2'b00, 3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0);  // bltu not taken
    run_req(2'b10, 3'b000, 32'h300, 32'h0, 32'h1003, 32'd0, 1'b0);        // misaligned jalr
    run_req(2'b10, 3'b000, 32'h300, 32'h0, 32'h1001, 32'd0, 1'b0);        // jalr to 0x1000
  endtask

  task automatic test_illegal();
    run_req(2'b00, 3'b010, 32'h400, 32'h8, 32'd7, 32'd7, 1'b0);
    run_req(2'b00, 3'b011, 32'h400, 32'h8, 32'd7, 32'd7, 1'b0);
    run_req(2'b11, 3'b000, 32'h400, 32'h8, 32'd7, 32'd7, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Fields changed while not ready must not be re-latched.
    for (int i = 0; i < 4; i++)
      run_req(2'b00, 3'b001, 32'h500 + 32'(i * 4), 32'h10, 32'd3, 32'd3, 1'b1);
  endtask

  task automatic test_kill();
    start_req(2'b01, 3'b000, 32'h600, 32'h10, 32'd0, 32'd0, 1'b0);
    kill = 1'b1; #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL kill_ready: got %b required 0", req_ready);
    end
    @(posedge clk); #1; kill = 1'b0; #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || flush !== 1'b0) begin
      errors++; $display("FAIL kill_eval: valid=%b ready=%b flush=%b required 0 1 0",
                         resp_valid, req_ready, flush);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || taken_cnt !== exp_cnt) begin
      errors++; $display("FAIL kill_eval_after: valid=%b cnt=%h required 0 %h",
                         resp_valid, taken_cnt, exp_cnt);
    end
    start_req(2'b01, 3'b000, 32'h700, 32'h10, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1; kill = 1'b1; #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_taken !== 1'b1) begin
      errors++; $display("FAIL kill_resp_vis: valid=%b taken=%b required 1 1", resp_valid, resp_taken);
    end
    @(posedge clk); #1; kill = 1'b0; #1;
    checks++;
    if (flush !== 1'b0 || req_ready !== 1'b1 || taken_cnt !== exp_cnt) begin
      errors++; $display("FAIL kill_resp: flush=%b ready=%b cnt=%h required 0 1 %h",
                         flush, req_ready, taken_cnt, exp_cnt);
    end
    start_req(2'b01, 3'b000, 32'h800, 32'h10, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (flush !== 1'b1) begin
      errors++; $display("FAIL kill_flush_pre: flush=%b required 1", flush);
    end
    kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0; #1;
    checks++;
    if (flush !== 1'b0 || req_ready !== 1'b1 || taken_cnt !== exp_cnt) begin
      errors++; $display("FAIL kill_flush: flush=%b ready=%b cnt=%h required 0 1 %h",
                         flush, req_ready, taken_cnt, exp_cnt);
    end
  endtask

  task automatic test_random();
    logic [1:0]  k;
    logic [31:0] imm, rs1, rs2, pc;
    for (int i = 0; i < 150; i++) begin
      k   = 2'($urandom_range(0, 3));
      pc  = $urandom & 32'hFFFF_FFFC;
      imm = $urandom;
      if ($urandom_range(0, 2) != 0) imm[1:0] = 2'b00;
      rs1 = $urandom;
      if ($urandom_range(0, 3) == 0) rs1[31] = ~rs1[31];
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      run_req(k, 3'($urandom), pc, imm, rs1, rs2, 1'($urandom));
    end
  endtask

  task automatic test_saturate();
    force dut.r_taken_cnt = 16'hFFFE;
    #2;
    release dut.r_taken_cnt;
    exp_cnt = 16'hFFFE;
    run_req(2'b01, 3'b000, 32'h900, 32'h8, 32'd0, 32'd0, 1'b0);
    run_req(2'b01, 3'b000, 32'h900, 32'h8, 32'd0, 32'd0, 1'b0);
    run_req(2'b01, 3'b000, 32'h900, 32'h8, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_async_reset();
    start_req(2'b01, 3'b000, 32'hA00, 32'h8, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_cnt = 16'd0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_req(2'b00, 3'b101, 32'hB00, 32'h10, 32'd9, 32'd2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_back_to_back();
    test_kill();
    test_random();
    test_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Sequencer for the execute-stage branch comparator. Accepts one branch or jump request at a time from decode over a valid/ready handshake, drives the comparator's funct3/operand inputs from latched registers, and samples its single-bit result. Computes the target, reports the outcome, and holds the front end in flush for a fixed number of cycles after every taken redirect. Sits between decode/issue and the fetch PC mux.

## Interface
- XLEN, 32, data/address width
- FLUSH_CYCLES, 2, cycles `flush` stays high after a taken redirect; legal values are 1 or greater

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_kind  in  2  00 branch, 01 jal, 10 jalr, 11 reserved
- req_funct3  in  3  branch condition (used for kind 00 only)
- req_pc  in  XLEN  PC of the instruction
- req_imm  in  XLEN  sign-extended offset
- req_rs1  in  XLEN  rs1 value
- req_rs2  in  XLEN  rs2 value
- cmp_funct3  out  3  comparator condition select
- cmp_op1  out  XLEN  comparator operand 1
- cmp_op2  out  XLEN  comparator operand 2
- cmp_br_sig  in  1  comparator result, combinational from cmp_* outputs
- kill  in  1  synchronous abort from trap logic; highest priority
- resp_valid  out  1  one-cycle outcome pulse
- resp_taken  out  1  redirect required
- resp_target  out  XLEN  redirect PC
- resp_link  out  XLEN  req_pc+4, used for the jal/jalr writeback
- resp_fault  out  1  misaligned target or illegal condition
- flush  out  1  squash younger instructions and stall fetch
- taken_cnt  out  16  saturating count of taken redirects

## Operation
- The FSM has four states: IDLE, EVAL, RESP and FLUSH. Reset enters IDLE.
- IDLE: `req_ready`=1. When `req_valid` && `req_ready`, the block latches all req_* fields and moves to EVAL.
- EVAL: `cmp_funct3`, `cmp_op1` and `cmp_op2` are driven from the latched funct3, rs1 and rs2. `cmp_br_sig` is sampled at the end of the cycle. The target is computed in the same cycle, and the block then moves to RESP.
  - Kind 00 or 01: target = pc+imm.
  - Kind 10: target = (rs1+imm) & ~1.
  - All additions are mod 2^XLEN with no overflow detection.
- Taken decision:
  - kind 00: taken = `cmp_br_sig`.
  - kind 01 or 10: always taken.
- Faults:
  - kind 00 with funct3 010 or 011 is an illegal condition; the comparator result is ignored.
  - Kind 11 is an illegal condition.
  - target[1]=1 on an otherwise-taken request is a misaligned target.
  - Any fault forces `resp_fault`=1 and `resp_taken`=0.
- RESP: `resp_valid`=1 for exactly one cycle.
  - If `resp_taken`=1: go to FLUSH and increment `taken_cnt`, which saturates at 16'hFFFF.
  - Otherwise: go to IDLE.
- FLUSH: `flush`=1 for FLUSH_CYCLES consecutive cycles, counted by an internal down-counter. The block then returns to IDLE.
- `kill`=1 in any state: the next state is IDLE, the flush counter clears, and the in-flight response is suppressed. If `kill` arrives in EVAL, no RESP pulse is produced. If `kill` arrives in RESP, that cycle's `resp_valid` is still visible, but FLUSH is skipped. `taken_cnt` is not incremented on a killed request, and `req_ready`=0 in the cycle `kill` is high.
- `cmp_*` outputs are 0 in IDLE, RESP and FLUSH.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_taken`=0, `resp_fault`=0, `resp_target`=0, `resp_link`=0, `flush`=0, `taken_cnt`=0, `cmp_*`=0.
- All resp_* outputs are registered. resp_* hold their last value when `resp_valid`=0; only the valid pulse is qualified.
- Latency from handshake cycle T:
  - EVAL at T+1.
  - `resp_valid` at T+2.
  - `flush` high T+3 through T+2+FLUSH_CYCLES.
  - `req_ready` again at T+3 if not taken, or T+3+FLUSH_CYCLES if taken.
- Throughput: one request per 3 cycles when not taken.
- `req_ready` is a function of state only (and `kill`), never of `req_valid`.
- Requests offered while `req_ready`=0 are ignored. The requester must hold its fields until accepted.

## Test plan
- beq, rs1=rs2=5, pc=0x100, imm=0x20 -> `resp_valid` at T+2, taken=1, target=0x120, link=0x104; `flush` high 2 cycles; `req_ready` returns at T+5; `taken_cnt`=1.
- blt, rs1=0xFFFFFFFF, rs2=1 -> during EVAL `cmp_funct3`=100, `cmp_op1`=0xFFFFFFFF, `cmp_op2`=1; taken=1. The same request as bltu (funct3=110) -> taken=0, no flush, `req_ready` at T+3.
- jalr, rs1=0x1003, imm=0 -> target=0x1002 with bit 1 set -> fault=1, taken=0, no flush. jalr with rs1=0x1001 -> target=0x1000, taken=1.
- funct3=010 with rs1=rs2, and kind=11 -> fault=1, taken=0; `taken_cnt` unchanged.
- `kill` asserted in EVAL -> no `resp_valid`, IDLE next cycle. `kill` asserted in the 1st FLUSH cycle -> `flush` drops the next cycle and `req_ready`=1.
- Preload `taken_cnt` via 65535 taken jal requests (or force), then one more -> stays 0xFFFF. Assert `rst_n`=0 mid-FLUSH -> all outputs return to reset values immediately (asynchronously).
